// File: rtl/niosiie_pio_pkg.sv
// Shared constants for the extended PIO: register word addresses and edge-capture sense codes.
package niosiie_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IN      = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/niosiie_pio_sync.sv
// Two-flop input synchroniser with a history flop; edges compares the synchronised value
// against the previous one using the selected sense.
module niosiie_pio_sync
    import niosiie_pio_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] sync,
    output logic [DATA_W-1:0] edges
);

    logic [DATA_W-1:0] sync1;
    logic [DATA_W-1:0] sync2;
    logic [DATA_W-1:0] prev;

    // All three stages clear together so the first post-reset cycle never sees an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_comb begin
        edges = sync2 & ~prev;
        if (EDGE_TYPE == EDGE_FALL) begin
            edges = ~sync2 & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edges = sync2 ^ prev;
        end
    end

    assign sync = sync2;

endmodule

// File: rtl/niosiie_pio_ext.sv
// Avalon-MM slave PIO: output register with atomic set/clear, synchronised input port,
// sticky edge capture and a maskable level interrupt.
module niosiie_pio_ext
    import niosiie_pio_pkg::*;
#(
    parameter int                DATA_W    = 24,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                EDGE_TYPE = EDGE_RISE,
    parameter int                IRQ_EN    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    // Bus handshake: zero wait states, no backpressure. A write is accepted on the rising
    // clk edge where chipselect=1 and write_n=0; readdata is valid combinationally for the
    // current address in the same cycle, whether or not chipselect is high.
    logic              wr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] irq_mask;
    logic [DATA_W-1:0] edge_cap;
    logic [DATA_W-1:0] cap_clr;
    logic [DATA_W-1:0] in_sync;
    logic [DATA_W-1:0] edges;
    logic [DATA_W-1:0] rd;
    logic              unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[DATA_W-1:0];
    assign unused_wd = ^writedata;

    niosiie_pio_sync #(
        .DATA_W    (DATA_W),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync    (in_sync),
        .edges   (edges)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VAL;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_out <= wd;
                ADDR_OUTSET: data_out <= data_out | wd;
                ADDR_OUTCLR: data_out <= data_out & ~wd;
                default:     data_out <= data_out;
            endcase
        end
    end

    // With the interrupt disabled the mask never leaves zero, so it also reads back as 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if ((IRQ_EN != 0) && wr && (address == ADDR_IRQMASK)) begin
            irq_mask <= wd;
        end
    end

    // A new edge is ORed in after the clear, so set wins over a same-cycle clear.
    assign cap_clr = (wr && (address == ADDR_EDGECAP)) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edges;
        end
    end

    always_comb begin
        rd = '0;
        case (address)
            ADDR_DATA:    rd = data_out;
            ADDR_IN:      rd = in_sync;
            ADDR_IRQMASK: rd = irq_mask;
            ADDR_EDGECAP: rd = edge_cap;
            default:      rd = '0;
        endcase
        readdata             = '0;
        readdata[DATA_W-1:0] = rd;
    end

    assign out_port = data_out;
    assign irq      = (IRQ_EN != 0) ? |(edge_cap & irq_mask) : 1'b0;

endmodule

// File: tb/tb_niosiie_pio_ext.sv
// Bench for niosiie_pio_ext: a 24-bit rising-edge instance and an 8-bit any-edge instance
// share one bus and are checked every cycle against an input-history model.
module tb_niosiie_pio_ext;
    import niosiie_pio_pkg::*;

    localparam logic [23:0] RV_A = 24'h00F00F;
    localparam logic [7:0]  RV_B = 8'hA5;
    localparam logic [31:0] MA   = 32'h00FF_FFFF;
    localparam logic [31:0] MB   = 32'h0000_00FF;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [23:0] in_a;
    logic [7:0]  in_b;
    logic [23:0] out_a;
    logic [7:0]  out_b;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic        irq_a;
    logic        irq_b;

    niosiie_pio_ext #(.DATA_W(24), .RESET_VAL(RV_A), .EDGE_TYPE(EDGE_RISE), .IRQ_EN(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a), .out_port(out_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    niosiie_pio_ext #(.DATA_W(8), .RESET_VAL(RV_B), .EDGE_TYPE(EDGE_ANY), .IRQ_EN(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b), .out_port(out_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and checker ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // h0/h1/h2 hold in_port as sampled on the last three edges; h1 is what IN shows,
    // and an edge between h2 and h1 is captured on the next clock.
    logic [31:0] ma_data, ma_mask, ma_cap, ha0, ha1, ha2;
    logic [31:0] mb_data, mb_mask, mb_cap, hb0, hb1, hb2;
    logic        wr_now;

    assign wr_now = chipselect & ~write_n;

    function automatic logic [31:0] edge_of(input logic [31:0] cur, input logic [31:0] prv,
                                            input int kind);
        if (kind == EDGE_FALL) return ~cur & prv;
        if (kind == EDGE_ANY)  return cur ^ prv;
        return cur & ~prv;
    endfunction

    function automatic logic [31:0] next_data(input logic [31:0] cur, input logic w,
                                              input logic [2:0] a, input logic [31:0] d);
        if (!w) return cur;
        if (a == 3'd0) return d;
        if (a == 3'd4) return cur | d;
        if (a == 3'd5) return cur & ~d;
        return cur;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [31:0] d,
                                               input logic [31:0] s, input logic [31:0] m,
                                               input logic [31:0] c);
        case (a)
            3'd0:    return d;
            3'd1:    return s;
            3'd2:    return m;
            3'd3:    return c;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma_data <= 32'(RV_A); ma_mask <= '0; ma_cap <= '0;
            ha0 <= '0; ha1 <= '0; ha2 <= '0;
            mb_data <= 32'(RV_B); mb_mask <= '0; mb_cap <= '0;
            hb0 <= '0; hb1 <= '0; hb2 <= '0;
        end else begin
            ma_data <= next_data(ma_data, wr_now, address, writedata & MA);
            ma_mask <= (wr_now && address == 3'd2) ? (writedata & MA) : ma_mask;
            ma_cap  <= (ma_cap & ~((wr_now && address == 3'd3) ? (writedata & MA) : 32'h0))
                       | (edge_of(ha1, ha2, EDGE_RISE) & MA);
            ha0 <= 32'(in_a); ha1 <= ha0; ha2 <= ha1;
            mb_data <= next_data(mb_data, wr_now, address, writedata & MB);
            mb_mask <= (wr_now && address == 3'd2) ? (writedata & MB) : mb_mask;
            mb_cap  <= (mb_cap & ~((wr_now && address == 3'd3) ? (writedata & MB) : 32'h0))
                       | (edge_of(hb1, hb2, EDGE_ANY) & MB);
            hb0 <= 32'(in_b); hb1 <= hb0; hb2 <= hb1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("out_a", 32'(out_a), ma_data);
        check("irq_a", 32'(irq_a), 32'(|(ma_cap & ma_mask)));
        check("readdata_a", readdata_a, model_read(address, ma_data, ha1, ma_mask, ma_cap));
        check("out_b", 32'(out_b), mb_data);
        check("irq_b", 32'(irq_b), 32'(|(mb_cap & mb_mask)));
        check("readdata_b", readdata_b, model_read(address, mb_data, hb1, mb_mask, mb_cap));
        if (exp_q.size() > 0) check("scoreboard_read_a", readdata_a, exp_q.pop_front());
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected read of dut_a, scored at the next falling edge.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        address = a;
        exp_q.push_back(exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_a       = '0;
        in_b       = '0;
        cyc(3);
        reset_n = 1'b1;
        #1;
        check("reset_out_a", 32'(out_a), 32'h0000_F00F);
        check("reset_irq_a", 32'(irq_a), 32'h0);
        rd(3'd0, 32'h0000_F00F); cyc();
        for (int a = 1; a < 8; a++) begin
            rd(3'(a), 32'h0);
            cyc();
        end

        // data / set / clear
        wr(3'd0, 32'h0012_3456); check("data_write", 32'(out_a), 32'h0012_3456);
        wr(3'd4, 32'h0000_00F0); check("outset", 32'(out_a), 32'h0012_34F6);
        wr(3'd5, 32'h0000_0006); check("outclr", 32'(out_a), 32'h0012_34F0);
        rd(3'd4, 32'h0); cyc();
        rd(3'd5, 32'h0); cyc();

        // rising edge on bit3, IN and EDGECAP latency, then mask
        in_a = 24'h000008;
        rd(3'd1, 32'h0); cyc();
        rd(3'd1, 32'h0); cyc();
        rd(3'd1, 32'h8); cyc();
        rd(3'd3, 32'h8);
        check("irq_unmasked", 32'(irq_a), 32'h0);
        cyc();
        wr(3'd2, 32'h0000_0008);
        check("irq_masked", 32'(irq_a), 32'h1);

        // clear coinciding with a new rising edge: set wins
        in_a = 24'h0;
        cyc(4);
        in_a = 24'h000008;
        cyc(2);
        wr(3'd3, 32'h0000_0008);
        rd(3'd3, 32'h8);
        check("irq_set_wins", 32'(irq_a), 32'h1);
        cyc();
        wr(3'd3, 32'h0000_0008);
        rd(3'd3, 32'h0);
        check("irq_cleared", 32'(irq_a), 32'h0);
        cyc();

        // any-edge capture on the 8-bit instance
        in_b = 8'h01;
        cyc(4);
        wr(3'd3, 32'h0000_00FF);
        in_b = 8'h80;
        cyc(4);
        address = 3'd3;
        #1 check("b_edgecap_any", readdata_b, 32'h0000_0081);
        wr(3'd0, 32'hFFFF_FF00);
        check("b_out_upper_ignored", 32'(out_b), 32'h0);
        check("a_out_upper_ignored", 32'(out_a), 32'h00FF_FF00);
        #1 check("b_read_zero_ext", readdata_b, 32'h0);
        wr(3'd2, 32'h0000_00FF);
        check("b_irq_before_reset", 32'(irq_b), 32'h1);

        // reset mid-capture
        reset_n = 1'b0;
        in_a    = '0;
        in_b    = '0;
        #1;
        check("rst_irq_b", 32'(irq_b), 32'h0);
        check("rst_out_b", 32'(out_b), 32'h0000_00A5);
        check("rst_out_a", 32'(out_a), 32'h0000_F00F);
        cyc(2);
        reset_n = 1'b1;
        cyc(5);
        address = 3'd3;
        #1;
        check("post_rst_cap_a", readdata_a, 32'h0);
        check("post_rst_cap_b", readdata_b, 32'h0);
        check("post_rst_irq_b", 32'(irq_b), 32'h0);
        cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_a = in_a ^ (24'h1 << $urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0) in_b = in_b ^ (8'h1 << $urandom_range(0, 7));
            reset_n = ($urandom_range(0, 299) != 0);
            cyc();
        end
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        cyc(2);

        if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/niosiie_pio_ext.md
Name: niosiie_pio_ext

Overview:
- Parametrised Avalon-MM slave PIO, next generation of the single-register output PIO that drives the hex displays.
- Adds atomic set/clear of output bits and a synchronised input port with edge capture and a maskable level interrupt.
- Sits on the NIOSIIe data master as a memory-mapped peripheral, 32-bit word bus, one register per word address.

Parameters:
- DATA_W, 24, width of out_port, in_port and all internal registers (1..32).
- RESET_VAL, 0, value loaded into the output register on reset (DATA_W bits).
- EDGE_TYPE, 0, edge-capture sense: 0 rising, 1 falling, 2 any.
- IRQ_EN, 1, 1 = irq driven from capture & mask; 0 = irq tied low and IRQMASK reads 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [DATA_W-1:0] used, upper bits ignored
- in_port  in  DATA_W  asynchronous external inputs
- out_port  out  DATA_W  registered output bits
- readdata  out  32  combinational read data, zero-extended above DATA_W
- irq  out  1  level interrupt

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-low (reset_n); all state clears immediately on reset_n low.
- Reset values: data_out=RESET_VAL, sync stages=0, prev=0, edgecap=0, irqmask=0; so out_port=RESET_VAL, irq=0.
- Write = chipselect & ~write_n; takes effect on the next rising clk edge.
- Register map, word address:
  - 0 DATA: R/W; write loads data_out; read returns data_out.
  - 1 IN: RO; read returns sync2 (synchronised in_port); writes ignored.
  - 2 IRQMASK: R/W; write loads mask.
  - 3 EDGECAP: read returns capture bits; write-1-to-clear per bit, 0 bits unaffected.
  - 4 OUTSET: WO; data_out <= data_out | wd. Reads 0.
  - 5 OUTCLR: WO; data_out <= data_out & ~wd. Reads 0.
  - 6, 7: reserved; read 0, writes ignored.
- readdata: purely combinational mux on address, independent of chipselect; zero read wait states.
- Input path per bit: sync1 <= in_port, sync2 <= sync1, prev <= sync2.
- Edge detect on sync2 vs prev: rising = sync2 & ~prev, falling = ~sync2 & prev, any = sync2 ^ prev.
- Latency: in_port change before edge E1 shows in IN after E2; EDGECAP bit set after E3; irq asserts the same cycle EDGECAP bit and mask are both 1.
- EDGECAP is sticky; stays set until cleared by a write or reset.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, bit stays 1.
- irq = |(edgecap & irqmask) when IRQ_EN=1; combinational from registers, glitch-free since both operands are flops.
- Changing the mask alone never alters EDGECAP; irq follows on the cycle after the mask write.
- Reset mid-operation: pending captures lost; the first post-reset cycle must not generate a spurious edge, because prev and sync2 are both 0.
- With DATA_W=32 no zero-extension; for DATA_W<32 upper readdata bits are 0.

Decomposition:
- Shared package niosiie_pio_pkg: address constants ADDR_DATA..ADDR_OUTCLR (3-bit), edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY.
- One sub-module niosiie_pio_sync: parametrised DATA_W two-flop synchroniser plus prev flop and edge-detect output, with EDGE_TYPE parameter.

Test Plan:
- Reset with RESET_VAL=24'h00F00F -> out_port=00F00F, irq=0, all readbacks 0 except DATA=0x00F00F.
- Write DATA=0x123456, then OUTSET=0x0000F0, then OUTCLR=0x000006 -> out_port 0x123456, 0x1234F6, 0x1234F0 on successive cycles; reads of addresses 4 and 5 return 0.
- EDGE_TYPE=0: drive in_port bit3 0->1 -> IN reads 0x8 two edges later; EDGECAP=0x8 on the third edge; irq stays 0 until IRQMASK=0x8 is written, then irq=1.
- Write EDGECAP=0x8 on the same cycle a new rising edge on bit3 is detected -> EDGECAP remains 0x8, irq stays 1; a later clear with no edge gives 0, irq=0.
- EDGE_TYPE=2, DATA_W=8: toggle bit0 1->0 and bit7 0->1 -> EDGECAP=0x81; writedata 0xFFFFFF00 to DATA -> out_port=0x00, readdata[31:8]=0.
- Assert reset_n low mid-capture (EDGECAP=0x81, mask=0xFF, irq=1) -> irq=0, out_port=RESET_VAL immediately; after release with in_port held constant, EDGECAP stays 0.
